ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter: the counterpart of the existing keyboard receive path (ps2_keyboard_interface).
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset, using the standard inhibit / request-to-send / device-clocked frame.
- Checks the device ACK bit.
- Sits in tty beside the receiver. Top level maps the enables onto the inout pins: ps2_clk = ps2_clk_oe ? 0 : z, and likewise for data.

---
 rtl/ps2_host_tx_if.sv | 25 ++
 rtl/ps2_host_tx.sv | 186 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the PS/2 host transmitter.
// The requester owns tx_data/tx_start; the transmitter reports busy/done/error.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_data,
        output tx_start,
        input  tx_busy,
        input  tx_done,
        input  tx_error
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output tx_busy,
        output tx_done,
        output tx_error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, then shifts
// one byte out on device-generated clock falls and checks the device ACK bit.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int RTS_CYCLES     = 250,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic           clk_50mhz,
    input  logic           reset,
    ps2_host_tx_if.slave   bus,
    input  logic           ps2_clk_in,
    input  logic           ps2_data_in,
    output logic           ps2_clk_oe,
    output logic           ps2_data_oe
);

    localparam int MAX_CNT = (TIMEOUT_CYCLES > INHIBIT_CYCLES)
                           ? ((TIMEOUT_CYCLES > RTS_CYCLES) ? TIMEOUT_CYCLES : RTS_CYCLES)
                           : ((INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES);
    localparam int CW = $clog2(MAX_CNT + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);

    localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] RTS_LAST  = CW'(RTS_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        WAIT_IDLE
    } state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    logic          clk_sync_p0, clk_sync_p1;
    logic          data_sync_p0, data_sync_p1;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_cnt;
    logic [7:0]    tx_byte;
    logic          parity_bit;
    logic          nack;
    logic          busy;
    logic          done;
    logic          err;
    logic          clk_oe;
    logic          data_oe;

    // Stage p0/p1: two-flop synchronizers for the asynchronous pin levels
    always_ff @(posedge clk_50mhz) begin
        clk_sync_p0  <= ps2_clk_in;
        clk_sync_p1  <= clk_sync_p0;
        data_sync_p0 <= ps2_data_in;
        data_sync_p1 <= data_sync_p0;
    end

    // Filter stage: a level change needs FILTER_LEN samples in a row that differ
    // from the current filtered level; a falling flip emits the one-cycle strobe.
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync_p1 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                clk_filt <= clk_sync_p1;
                filt_cnt <= '0;
                fall     <= clk_filt;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    // Frame FSM: all outputs registered; timeout is checked ahead of fall.
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            nack    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            clk_oe  <= 1'b0;
            data_oe <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.tx_start) begin
                        tx_byte    <= bus.tx_data;
                        parity_bit <= odd_parity(bus.tx_data);
                        state      <= INHIBIT;
                        busy       <= 1'b1;
                        clk_oe     <= 1'b1;
                        cnt        <= '0;
                    end
                end
                INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        state   <= RTS;
                        data_oe <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RTS: begin
                    if (cnt == RTS_LAST) begin
                        state   <= SEND;
                        clk_oe  <= 1'b0;
                        cnt     <= '0;
                        bit_cnt <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SEND: begin
                    if (cnt == TO_LAST) begin
                        state   <= IDLE;
                        clk_oe  <= 1'b0;
                        data_oe <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end else if (fall) begin
                        cnt     <= '0;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt < 4'd8) begin
                            data_oe <= ~tx_byte[bit_cnt[2:0]];
                        end else if (bit_cnt == 4'd8) begin
                            data_oe <= ~parity_bit;
                        end else if (bit_cnt == 4'd9) begin
                            data_oe <= 1'b0;
                        end else begin
                            nack  <= data_sync_p1;
                            state <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (cnt == TO_LAST) begin
                        state   <= IDLE;
                        clk_oe  <= 1'b0;
                        data_oe <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end else if (clk_filt && data_sync_p1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= nack;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx_busy  = busy;
    assign bus.tx_done  = done;
    assign bus.tx_error = err;
    assign ps2_clk_oe   = clk_oe;
    assign ps2_data_oe  = data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of
// the DUT over open-drain wired lines and the captured bits are compared to hand values.
module tb_ps2_host_tx;

    localparam int INH = 50;
    localparam int RTS = 10;
    localparam int TO  = 2000;
    localparam int H   = 40;

    logic clk_50mhz = 1'b0;
    logic reset     = 1'b1;
    logic dev_clk   = 1'b1;
    logic dev_data  = 1'b1;
    logic ps2_clk_oe, ps2_data_oe;
    logic clk_line, data_line;
    logic [10:0] fr_bits;

    int n_vec  = 0;
    int n_miss = 0;

    always #10 clk_50mhz = ~clk_50mhz;

    ps2_host_tx_if ifc ();

    assign clk_line  = ~ps2_clk_oe & dev_clk;
    assign data_line = ~ps2_data_oe & dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .RTS_CYCLES     (RTS),
        .TIMEOUT_CYCLES (TO),
        .FILTER_LEN     (8)
    ) dut (
        .clk_50mhz   (clk_50mhz),
        .reset       (reset),
        .bus         (ifc.slave),
        .ps2_clk_in  (clk_line),
        .ps2_data_in (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_start(input logic [7:0] d);
        @(negedge clk_50mhz);
        ifc.tx_data  = d;
        ifc.tx_start = 1'b1;
        @(negedge clk_50mhz);
        ifc.tx_start = 1'b0;
    endtask

    task automatic wait_release(input string tag);
        int k = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && k < 5000) begin
            @(negedge clk_50mhz);
            k++;
        end
        check_vec({tag, "_rts_seen"}, 32'(k < 5000), 32'd1);
    endtask

    // Device: samples start before clocking, then each bit on clock rise 1..10,
    // drives ACK low between rise 10 and rise 11 when asked to.
    task automatic dev_frame(input string tag, input bit ack, input bit glitch,
                             output logic [10:0] bits);
        bits = '1;
        wait_release(tag);
        repeat (H) @(negedge clk_50mhz);
        bits[0] = data_line;
        for (int i = 1; i <= 11; i++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk_50mhz);
            dev_clk = 1'b1;
            if (i <= 10) bits[i] = data_line;
            if (i == 10 && ack) dev_data = 1'b0;
            if (i == 11) begin
                dev_data = 1'b1;
                break;
            end
            if (glitch && (i == 2 || i == 5 || i == 8)) begin
                repeat (10) @(negedge clk_50mhz);
                dev_clk = 1'b0;
                repeat (3) @(negedge clk_50mhz);
                dev_clk = 1'b1;
                repeat (H - 13) @(negedge clk_50mhz);
            end else begin
                repeat (H) @(negedge clk_50mhz);
            end
        end
    endtask

    task automatic wait_done(input string tag, input logic exp_err);
        int k = 0;
        while (!ifc.tx_done && k < 200) begin
            @(negedge clk_50mhz);
            k++;
        end
        check_vec({tag, "_done"}, 32'(ifc.tx_done), 32'd1);
        check_vec({tag, "_err"}, 32'(ifc.tx_error), 32'(exp_err));
        check_vec({tag, "_busy"}, 32'(ifc.tx_busy), 32'd0);
        @(negedge clk_50mhz);
        check_vec({tag, "_after"}, {28'd0, ifc.tx_done, ifc.tx_error, ps2_clk_oe, ps2_data_oe}, 32'd0);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input bit ack,
                             input logic [10:0] exp_bits);
        send_start(d);
        dev_frame(tag, ack, 1'b0, fr_bits);
        check_vec({tag, "_bits"}, 32'(fr_bits), 32'(exp_bits));
        wait_done(tag, ~ack);
    endtask

    initial begin
        int k;
        ifc.tx_data  = 8'h00;
        ifc.tx_start = 1'b0;
        repeat (3) @(negedge clk_50mhz);
        check_vec("reset_state",
                  {27'd0, ps2_clk_oe, ps2_data_oe, ifc.tx_busy, ifc.tx_done, ifc.tx_error}, 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk_50mhz);

        // 1: timing of inhibit / RTS and a full 0xED frame
        send_start(8'hED);
        check_vec("accept", {29'd0, ifc.tx_busy, ps2_clk_oe, ps2_data_oe}, 32'b110);
        k = 0;
        while (ps2_clk_oe && !ps2_data_oe && k < 10000) begin
            k++;
            @(negedge clk_50mhz);
        end
        check_vec("inhibit_len", 32'(k), 32'(INH));
        check_vec("rts_clk_low", 32'(ps2_clk_oe), 32'd1);
        k = 0;
        while (ps2_clk_oe && k < 10000) begin
            k++;
            @(negedge clk_50mhz);
        end
        check_vec("rts_len", 32'(k), 32'(RTS));
        dev_frame("ed", 1'b1, 1'b0, fr_bits);
        check_vec("ed_bits", 32'(fr_bits), 32'({1'b1, 1'b1, 8'hED, 1'b0}));
        wait_done("ed", 1'b0);

        // 2: parity
        run_frame("p00", 8'h00, 1'b1, {1'b1, 1'b1, 8'h00, 1'b0});
        check_vec("p00_parity", 32'(fr_bits[9]), 32'd1);
        run_frame("p01", 8'h01, 1'b1, {1'b1, 1'b0, 8'h01, 1'b0});
        check_vec("p01_parity", 32'(fr_bits[9]), 32'd0);
        run_frame("pff", 8'hFF, 1'b1, {1'b1, 1'b1, 8'hFF, 1'b0});
        check_vec("pff_parity", 32'(fr_bits[9]), 32'd1);

        // 3: NACK
        run_frame("nack", 8'hED, 1'b0, {1'b1, 1'b1, 8'hED, 1'b0});

        // 4: device never clocks
        send_start(8'h12);
        wait_release("to");
        k = 0;
        while (!ifc.tx_done && k < TO + 100) begin
            @(negedge clk_50mhz);
            k++;
        end
        check_vec("to_len", 32'(k), 32'(TO));
        check_vec("to_flags", {28'd0, ifc.tx_done, ifc.tx_error, ps2_clk_oe, ps2_data_oe}, 32'b1100);
        check_vec("to_busy", 32'(ifc.tx_busy), 32'd0);
        run_frame("post_to", 8'hED, 1'b1, {1'b1, 1'b1, 8'hED, 1'b0});

        // 5: clock glitches plus a start request while busy
        send_start(8'h3C);
        fork
            dev_frame("gl", 1'b1, 1'b1, fr_bits);
            begin
                repeat (300) @(negedge clk_50mhz);
                ifc.tx_data  = 8'h55;
                ifc.tx_start = 1'b1;
                @(negedge clk_50mhz);
                check_vec("gl_busy_mid", 32'(ifc.tx_busy), 32'd1);
                ifc.tx_start = 1'b0;
            end
        join
        check_vec("gl_bits", 32'(fr_bits), 32'({1'b1, 1'b1, 8'h3C, 1'b0}));
        wait_done("gl", 1'b0);

        // 6: reset after four falls, then a clean 0xF4 frame
        send_start(8'hA5);
        wait_release("rst");
        repeat (H) @(negedge clk_50mhz);
        repeat (4) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk_50mhz);
            dev_clk = 1'b1;
            repeat (H) @(negedge clk_50mhz);
        end
        check_vec("rst_pre", {30'd0, ifc.tx_busy, ps2_data_oe}, 32'b11);
        reset = 1'b1;
        @(negedge clk_50mhz);
        check_vec("rst_mid",
                  {27'd0, ps2_clk_oe, ps2_data_oe, ifc.tx_busy, ifc.tx_done, ifc.tx_error}, 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk_50mhz);
        run_frame("f4", 8'hF4, 1'b1, {1'b1, 1'b0, 8'hF4, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
